ssd_scan_driver: RTL
====================

SSD_SCAN_DRIVER -- requirements
Module: ssd_scan_driver

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide DIGITS, 8, number of multiplexed digits; legal range 1..16.
REQ-002 The block SHALL provide REFRESH_DIV, 100000, clock cycles per digit display slot; legal values are multiples of 16, minimum 16.
REQ-003 The block SHALL provide BLANK_CYCLES, 16, anti-ghosting cycles with all anodes off before each slot; 0 disables the blank interval.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL provide ssd_scan_port_clk, in, 1, the single clock for all logic.
REQ-005 The block SHALL provide ssd_scan_port_rst_n, in, 1, reset; asynchronous, active-low.
REQ-006 The block SHALL provide ssd_scan_port_data_in, in, 5*DIGITS, one 5-bit symbol code per digit; digit k occupies [5k+4:5k].
REQ-007 The block SHALL provide ssd_scan_port_dp_in, in, DIGITS, decimal point per digit, 1 = lit.
REQ-008 The block SHALL provide ssd_scan_port_en_in, in, DIGITS, digit enable, 1 = digit shown.
REQ-009 The block SHALL provide ssd_scan_port_load, in, 1, frame-load request.
REQ-010 The block SHALL provide ssd_scan_port_load_ack, out, 1, one-cycle pulse when the frame is captured.
REQ-011 The block SHALL provide ssd_scan_port_cc, out, 7, segments {g,f,e,d,c,b,a}, active-low.
REQ-012 The block SHALL provide ssd_scan_port_dp_out, out, 1, decimal point, active-low.
REQ-013 The block SHALL provide ssd_scan_port_an_out, out, DIGITS, anodes, active-low, at most one bit low at a time.
REQ-014 The block SHALL provide ssd_scan_port_digit_idx, out, clog2(DIGITS) (minimum 1), index of the current slot.

Function
REQ-015 The segment encoding SHALL use these patterns:
- codes 0x00-0x0F: standard hex glyphs 0-9, A, b, C, d, E, F; 0x00 = 1000000, 0x08 = 0000000, 0x0A = 0001000.
- 0x10 = 0101110, 0x11 = 0011010, 0x12 = 0011101, 0x13 = 0111111, 0x14 = 0001001, 0x15 = 0110110.
- 0x16-0x1F: 1111111 (blank).
REQ-016 The FSM SHALL have two states:
- BLANK: lasts BLANK_CYCLES cycles; all anodes high, cc = 1111111, dp_out = 1.
- SHOW: lasts REFRESH_DIV cycles; an_out[idx] low only if the shadow enable for idx = 1.
REQ-017 The FSM SHALL cycle BLANK->SHOW->BLANK; when BLANK_CYCLES = 0, BLANK SHALL be skipped.
REQ-018 digit_idx SHALL increment at each SHOW exit and wrap from DIGITS-1 to 0.
REQ-019 cc, dp_out and an_out SHALL be registered and SHALL reflect the shadow frame for the current idx, with no combinational path from the inputs.
REQ-020 A disabled digit SHALL still occupy its full slot with its anode high and cc blank.
REQ-021 A load pulse SHALL set an internal pending flag; a load while pending is already set SHALL have no further effect.
REQ-022 Capture SHALL occur on the last SHOW cycle of any slot when pending = 1:
- data_in, dp_in and en_in are sampled into the shadow registers.
- load_ack pulses in the same cycle.
- pending clears.
- The producer SHALL hold the inputs stable until load_ack.
REQ-023 load asserted in the capture cycle itself SHALL be captured in that cycle; pending ends clear.
REQ-024 Worst-case load-to-ack latency SHALL be DIGITS... no: it SHALL be BLANK_CYCLES+REFRESH_DIV cycles (one slot).

Reset
REQ-025 On rst_n low, asynchronously:
- FSM enters BLANK, idx = 0, timers = 0, pending = 0.
- shadow data = 0, dp = 0, en = 0.
- an_out all 1, cc = 1111111, dp_out = 1, load_ack = 0.
REQ-026 Reset mid-slot or mid-load SHALL discard the pending request; scanning SHALL restart at digit 0 after release.

Configuration
REQ-027 Macro SSD_SCAN_DIM_EN, when defined:
- adds input ssd_scan_port_bright, 4 bits.
- each SHOW slot is split into 16 equal sub-periods of REFRESH_DIV/16 cycles.
- the anode is low only for sub-periods 0..bright; bright = 15 gives full on.
- bright is sampled at each slot start.
REQ-028 When SSD_SCAN_DIM_EN is undefined, the bright port SHALL be absent and the anode SHALL be low for the whole SHOW slot.

Verification (DIGITS=4, REFRESH_DIV=16, BLANK_CYCLES=2)
REQ-029 Reset, then load data = {0x3,0x2,0x1,0x0}, en = 1111 -> ack within 18 cycles; an_out sequence 1110, 1101, 1011, 0111, each low 16 cycles with 2-cycle 1111 gaps; cc 1000000, 1111001, 0100100, 0110000.
REQ-030 Codes 0x15, 0x1F, dp_in = 0001 -> digit 0 cc 0110110 with dp_out 0; digit 1 cc 1111111.
REQ-031 en = 1010 -> digits 0 and 2 keep an_out all 1 during their slots; timing unchanged.
REQ-032 load held high 3 cycles mid-slot, then a second load before ack -> exactly one ack, on the slot's last SHOW cycle.
REQ-033 rst_n low mid-SHOW of digit 2 with load pending -> outputs reset immediately; no ack after release; scan resumes at digit 0.
REQ-034 SSD_SCAN_DIM_EN defined, bright = 3 -> anode low 4 cycles of each 16-cycle slot; bright = 15 -> 16 cycles.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered frame load.
// Optional per-slot PWM dimming is enabled by defining SSD_SCAN_DIM_EN.
module ssd_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                                        ssd_scan_port_clk,
    input  logic                                        ssd_scan_port_rst_n,
    input  logic [5*DIGITS-1:0]                         ssd_scan_port_data_in,
    input  logic [DIGITS-1:0]                           ssd_scan_port_dp_in,
    input  logic [DIGITS-1:0]                           ssd_scan_port_en_in,
    input  logic                                        ssd_scan_port_load,
`ifdef SSD_SCAN_DIM_EN
    input  logic [3:0]                                  ssd_scan_port_bright,
`endif
    output logic                                        ssd_scan_port_load_ack,
    output logic [6:0]                                  ssd_scan_port_cc,
    output logic                                        ssd_scan_port_dp_out,
    output logic [DIGITS-1:0]                           ssd_scan_port_an_out,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] ssd_scan_port_digit_idx
);

    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t              state, nxt_state;
    logic [CW-1:0]       cnt, nxt_cnt;
    logic [IW-1:0]       idx, nxt_idx;
    logic                pending;
    logic [5*DIGITS-1:0] shadow_data, f_data;
    logic [DIGITS-1:0]   shadow_dp, shadow_en, f_dp, f_en;
    logic                blank_done, show_done, capture, lit;
    logic [4:0]          sym;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          cc_d;
    logic                dp_d;
`ifdef SSD_SCAN_DIM_EN
    localparam int SUB = REFRESH_DIV / 16;
    logic [3:0]          bright_q, bright_eff;
`endif

    function automatic logic [6:0] seg7(input logic [4:0] code);
        case (code)
            5'h00: seg7 = 7'b1000000;
            5'h01: seg7 = 7'b1111001;
            5'h02: seg7 = 7'b0100100;
            5'h03: seg7 = 7'b0110000;
            5'h04: seg7 = 7'b0011001;
            5'h05: seg7 = 7'b0010010;
            5'h06: seg7 = 7'b0000010;
            5'h07: seg7 = 7'b1111000;
            5'h08: seg7 = 7'b0000000;
            5'h09: seg7 = 7'b0010000;
            5'h0A: seg7 = 7'b0001000;
            5'h0B: seg7 = 7'b0000011;
            5'h0C: seg7 = 7'b1000110;
            5'h0D: seg7 = 7'b0100001;
            5'h0E: seg7 = 7'b0000110;
            5'h0F: seg7 = 7'b0001110;
            5'h10: seg7 = 7'b0101110;
            5'h11: seg7 = 7'b0011010;
            5'h12: seg7 = 7'b0011101;
            5'h13: seg7 = 7'b0111111;
            5'h14: seg7 = 7'b0001001;
            5'h15: seg7 = 7'b0110110;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign blank_done = (BLANK_CYCLES == 0) || (cnt == CW'(BLANK_CYCLES - 1));
    assign show_done  = (state == SHOW) && (cnt == CW'(REFRESH_DIV - 1));
    assign capture    = show_done && (pending || ssd_scan_port_load);

    assign ssd_scan_port_load_ack  = capture;
    assign ssd_scan_port_digit_idx = idx;

    // Outputs are registered from the next-cycle state so they line up with it;
    // a frame captured this cycle is forwarded so a zero-blank config shows it at once.
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt + CW'(1);
        nxt_idx   = idx;
        case (state)
            BLANK: if (blank_done) begin
                nxt_state = SHOW;
                nxt_cnt   = '0;
            end
            SHOW: if (show_done) begin
                nxt_cnt   = '0;
                nxt_idx   = (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
                nxt_state = (BLANK_CYCLES == 0) ? SHOW : BLANK;
            end
            default: nxt_state = BLANK;
        endcase

        f_data = capture ? ssd_scan_port_data_in : shadow_data;
        f_dp   = capture ? ssd_scan_port_dp_in   : shadow_dp;
        f_en   = capture ? ssd_scan_port_en_in   : shadow_en;
        sym    = f_data[5*nxt_idx +: 5];
        lit    = (nxt_state == SHOW) && f_en[nxt_idx];
`ifdef SSD_SCAN_DIM_EN
        bright_eff = ((nxt_state == SHOW) && (nxt_cnt == '0)) ? ssd_scan_port_bright : bright_q;
        lit        = lit && ((nxt_cnt / CW'(SUB)) <= CW'(bright_eff));
`endif
        an_d = '1;
        if (lit) an_d[nxt_idx] = 1'b0;
        cc_d = lit ? seg7(sym) : '1;
        dp_d = lit ? ~f_dp[nxt_idx] : 1'b1;
    end

    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            state                <= BLANK;
            cnt                  <= '0;
            idx                  <= '0;
            pending              <= 1'b0;
            shadow_data          <= '0;
            shadow_dp            <= '0;
            shadow_en            <= '0;
            ssd_scan_port_an_out <= '1;
            ssd_scan_port_cc     <= '1;
            ssd_scan_port_dp_out <= 1'b1;
`ifdef SSD_SCAN_DIM_EN
            bright_q             <= '0;
`endif
        end else begin
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            idx     <= nxt_idx;
            pending <= capture ? 1'b0 : (pending | ssd_scan_port_load);
            if (capture) begin
                shadow_data <= ssd_scan_port_data_in;
                shadow_dp   <= ssd_scan_port_dp_in;
                shadow_en   <= ssd_scan_port_en_in;
            end
            ssd_scan_port_an_out <= an_d;
            ssd_scan_port_cc     <= cc_d;
            ssd_scan_port_dp_out <= dp_d;
`ifdef SSD_SCAN_DIM_EN
            bright_q             <= bright_eff;
`endif
        end
    end

endmodule
